// File: rtl/coeff_sequencer.sv
// Copies one coefficient set from the register file into the crossover filter
// shadow registers, then commits it on the next audio sample strobe.
module coeff_sequencer #(
  parameter int DATA_W     = 32,
  parameter int NUM_COEFFS = 10
) (
  input  logic              i_clk_sys,
  input  logic              i_rstn,
  input  logic              i_coeffs_rdy,
  output logic [3:0]        o_reg_addr,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_sample_strobe,
  output logic [3:0]        o_coeff_sel,
  output logic [DATA_W-1:0] o_coeff_data,
  output logic              o_coeff_wr,
  output logic              o_coeff_commit,
  output logic              o_busy,
  output logic              o_abort,
  output logic [7:0]        o_commit_cnt,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CAPT   = 3'd3;
  localparam logic [2:0] S_WT_SMP = 3'd4;

  localparam logic [3:0] LAST_IDX = 4'(NUM_COEFFS - 1);

  logic [2:0] state;
  logic [3:0] idx;

  assign dbg_state = state;

  // Handshake: there is no back-pressure anywhere. i_coeffs_rdy and
  // i_sample_strobe are single-cycle pulses that are sampled once, and
  // o_coeff_wr / o_coeff_commit / o_abort are single-cycle pulses that the
  // filters must take on the cycle they are high.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rstn) begin
      state          <= S_IDLE;
      idx            <= 4'd0;
      o_reg_addr     <= 4'd0;
      o_coeff_sel    <= 4'd0;
      o_coeff_data   <= '0;
      o_coeff_wr     <= 1'b0;
      o_coeff_commit <= 1'b0;
      o_busy         <= 1'b0;
      o_abort        <= 1'b0;
      o_commit_cnt   <= 8'd0;
    end else begin
      o_coeff_wr     <= 1'b0;
      o_coeff_commit <= 1'b0;
      o_abort        <= 1'b0;
      // A new set arriving mid-sequence restarts the walk; any write or
      // commit the current state would have produced this edge is dropped.
      if (state != S_IDLE && i_coeffs_rdy) begin
        o_abort    <= 1'b1;
        idx        <= 4'd0;
        o_reg_addr <= 4'd0;
        state      <= S_ISSUE;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_coeffs_rdy) begin
              idx        <= 4'd0;
              o_reg_addr <= 4'd0;
              o_busy     <= 1'b1;
              state      <= S_ISSUE;
            end
          end
          S_ISSUE: state <= S_WAIT;
          S_WAIT:  state <= S_CAPT;
          S_CAPT: begin
            o_coeff_data <= i_reg_data;
            o_coeff_sel  <= idx;
            o_coeff_wr   <= 1'b1;
            if (idx < LAST_IDX) begin
              idx        <= idx + 4'd1;
              o_reg_addr <= idx + 4'd1;
              state      <= S_ISSUE;
            end else begin
              state <= S_WT_SMP;
            end
          end
          S_WT_SMP: begin
            if (i_sample_strobe) begin
              o_coeff_commit <= 1'b1;
              o_busy         <= 1'b0;
              o_commit_cnt   <= o_commit_cnt + 8'd1;
              state          <= S_IDLE;
            end
          end
          default: begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coeff_sequencer.sv
// Directed bench for coeff_sequencer: register file model, write scoreboard,
// commit/abort monitors and a final report.
module tb_coeff_sequencer;

  localparam int DATA_W = 32;
  localparam int N      = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              rdy = 1'b0;
  logic              strobe = 1'b0;
  logic [3:0]        reg_addr;
  logic [DATA_W-1:0] reg_data;
  logic [3:0]        coeff_sel;
  logic [DATA_W-1:0] coeff_data;
  logic              coeff_wr;
  logic              coeff_commit;
  logic              busy;
  logic              abort;
  logic [7:0]        commit_cnt;
  logic [2:0]        dbg_state;

  coeff_sequencer #(.DATA_W(DATA_W), .NUM_COEFFS(N)) dut (
    .i_clk_sys      (clk),
    .i_rstn         (rstn),
    .i_coeffs_rdy   (rdy),
    .o_reg_addr     (reg_addr),
    .i_reg_data     (reg_data),
    .i_sample_strobe(strobe),
    .o_coeff_sel    (coeff_sel),
    .o_coeff_data   (coeff_data),
    .o_coeff_wr     (coeff_wr),
    .o_coeff_commit (coeff_commit),
    .o_busy         (busy),
    .o_abort        (abort),
    .o_commit_cnt   (commit_cnt),
    .dbg_state      (dbg_state)
  );

  // Register file: address sampled on one edge, data out on the next.
  logic [DATA_W-1:0] mem [16];
  logic [3:0]        addr_q = 4'd0;
  initial reg_data = '0;
  always @(posedge clk) begin
    addr_q   <= reg_addr;
    reg_data <= mem[addr_q];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [51:0] exp_q[$];   // {edge[15:0], sel[3:0], data[31:0]}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  int wr_n = 0, commit_n = 0, commit_cyc = -1, abort_n = 0, abort_cyc = -1;

  always @(negedge clk) begin
    logic [51:0] e;
    if (coeff_wr) begin
      wr_n++;
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_edge", cyc, e[51:36]);
        check("wr_sel", coeff_sel, e[35:32]);
        check("wr_data", coeff_data, e[31:0]);
      end
    end
    if (coeff_commit) begin
      commit_n++;
      commit_cyc = cyc;
    end
    if (abort) begin
      abort_n++;
      abort_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_set(input int base, input int count);
    for (int k = 0; k < count; k++)
      exp_q.push_back({16'(base + 3 * (k + 1)), 4'(k), mem[k]});
  endtask

  // Drive rdy/strobe so that posedge number e samples them.
  task automatic drive_at(input int e, input logic r, input logic s);
    while (cyc + 1 < e) @(negedge clk);
    rdy = r;
    strobe = s;
    @(negedge clk);
    rdy = 1'b0;
    strobe = 1'b0;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int e0, c0, a0, w0, d;
  int exp_cnt;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wr", coeff_wr, 0);
    check("rst_commit", coeff_commit, 0);
    check("rst_abort", abort, 0);
    check("rst_cnt", commit_cnt, 0);
    check("rst_sel", coeff_sel, 0);
    check("rst_data", coeff_data, 0);
    check("rst_state", dbg_state, 0);
    rstn = 1'b1;
    exp_cnt = 0;
    @(negedge clk);

    // basic sequence
    e0 = cyc + 2;
    expect_set(e0, N);
    c0 = commit_n;
    drive_at(e0, 1'b1, 1'b0);
    wait_until(e0 + 5);
    check("t1_busy_mid", busy, 1);
    drive_at(e0 + 40, 1'b0, 1'b1);
    wait_until(e0 + 41);
    exp_cnt++;
    check("t1_commits", commit_n - c0, 1);
    check("t1_commit_edge", commit_cyc, e0 + 40);
    check("t1_busy_done", busy, 0);
    check("t1_cnt", commit_cnt, exp_cnt);
    check("t1_q_empty", exp_q.size(), 0);

    // strobes during load are ignored
    @(negedge clk);
    e0 = cyc + 2;
    expect_set(e0, N);
    c0 = commit_n;
    drive_at(e0, 1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) drive_at(e0 + 8 * i, 1'b0, 1'b1);
    wait_until(e0 + 45);
    exp_cnt++;
    check("t2_commits", commit_n - c0, 1);
    check("t2_commit_edge", commit_cyc, e0 + 32);
    check("t2_cnt", commit_cnt, exp_cnt);

    // abort mid-load
    @(negedge clk);
    e0 = cyc + 2;
    expect_set(e0, 4);
    expect_set(e0 + 13, N);
    c0 = commit_n;
    a0 = abort_n;
    drive_at(e0, 1'b1, 1'b0);
    drive_at(e0 + 13, 1'b1, 1'b0);
    wait_until(e0 + 13);
    check("t3_aborts", abort_n - a0, 1);
    check("t3_abort_edge", abort_cyc, e0 + 13);
    check("t3_addr", reg_addr, 0);
    check("t3_busy", busy, 1);
    drive_at(e0 + 50, 1'b0, 1'b1);
    wait_until(e0 + 51);
    exp_cnt++;
    check("t3_commits", commit_n - c0, 1);
    check("t3_commit_edge", commit_cyc, e0 + 50);
    check("t3_cnt", commit_cnt, exp_cnt);

    // abort in WT_SMP: rdy and strobe on the same edge
    @(negedge clk);
    e0 = cyc + 2;
    expect_set(e0, N);
    expect_set(e0 + 35, N);
    c0 = commit_n;
    a0 = abort_n;
    drive_at(e0, 1'b1, 1'b0);
    drive_at(e0 + 35, 1'b1, 1'b1);
    wait_until(e0 + 70);
    check("t4_no_commit", commit_n - c0, 0);
    check("t4_cnt_hold", commit_cnt, exp_cnt);
    check("t4_abort_edge", abort_cyc, e0 + 35);
    check("t4_aborts", abort_n - a0, 1);
    check("t4_busy", busy, 1);
    drive_at(e0 + 75, 1'b0, 1'b1);
    wait_until(e0 + 76);
    exp_cnt++;
    check("t4_commits", commit_n - c0, 1);
    check("t4_commit_edge", commit_cyc, e0 + 75);
    check("t4_cnt", commit_cnt, exp_cnt);

    // reset mid-operation
    @(negedge clk);
    e0 = cyc + 2;
    expect_set(e0, 3);
    c0 = commit_n;
    drive_at(e0, 1'b1, 1'b0);
    while (cyc + 1 < e0 + 10) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    check("t5_busy", busy, 0);
    check("t5_addr", reg_addr, 0);
    check("t5_wr", coeff_wr, 0);
    check("t5_cnt", commit_cnt, 0);
    check("t5_state", dbg_state, 0);
    @(negedge clk);
    rstn = 1'b1;
    exp_cnt = 0;
    wait_until(e0 + 40);
    check("t5_q_empty", exp_q.size(), 0);
    check("t5_no_commit", commit_n - c0, 0);
    e0 = cyc + 2;
    expect_set(e0, N);
    drive_at(e0, 1'b1, 1'b0);
    drive_at(e0 + 31, 1'b0, 1'b1);
    wait_until(e0 + 32);
    exp_cnt++;
    check("t5_commit_edge", commit_cyc, e0 + 31);
    check("t5_cnt_after", commit_cnt, exp_cnt);

    // counter wrap; a strobe coincident with the last capture is ignored
    for (int s = 0; s < 256; s++) begin
      @(negedge clk);
      e0 = cyc + 2;
      expect_set(e0, N);
      c0 = commit_n;
      w0 = wr_n;
      d = $urandom_range(0, 4);
      drive_at(e0, 1'b1, 1'b0);
      drive_at(e0 + 30, 1'b0, 1'b1);
      drive_at(e0 + 31 + d, 1'b0, 1'b1);
      wait_until(e0 + 32 + d);
      exp_cnt = (exp_cnt + 1) % 256;
      check("t6_commits", commit_n - c0, 1);
      check("t6_commit_edge", commit_cyc, e0 + 31 + d);
      check("t6_writes", wr_n - w0, N);
      check("t6_cnt", commit_cnt, exp_cnt);
    end

    check("final_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
